obj_affine_seq: RTL

Sequences one affine (rotated/scaled) OBJ across the current scanline. The block fetches the object's PA/PB/PC/PD group from OAM over a req/ack port and computes the starting texel position once. It then steps the texel coordinates incrementally, one screen column per cycle, and emits a valid/ready pixel stream to the OBJ line-buffer writer. It sits between the OBJ attribute scanner, which issues `start`, and the OBJ pixel/palette stage.

---
 rtl/obj_pkg.sv | 20 ++
 rtl/obj_affine_stepper.sv | 72 +++++++
 rtl/obj_affine_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/obj_pkg.sv
// Shared types and constants for the OBJ affine sequencing path.
package obj_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FETCH,
    ST_SETUP,
    ST_RUN,
    ST_DONE
  } obj_state_t;

  localparam int OAM_AFF_BASE     = 3;
  localparam int OAM_AFF_STRIDE   = 4;
  localparam int OAM_GROUP_STRIDE = 16;

  localparam int ACC_W  = 28;
  localparam int FRAC_W = 8;

endpackage

// File: rtl/obj_affine_stepper.sv
// Texel accumulators for one affine OBJ: start-value multiplies, per-column
// stepping with freeze, and texel/transparency decode.
module obj_affine_stepper
  import obj_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] pa,
  input  logic [15:0] pb,
  input  logic [15:0] pc,
  input  logic [15:0] pd,
  input  logic [7:0]  ry,
  input  logic [7:0]  half_w,
  input  logic [7:0]  half_h,
  input  logic [7:0]  hsize,
  input  logic [7:0]  vsize,
  output logic [5:0]  tx,
  output logic [5:0]  ty,
  output logic        transparent
);

  logic signed [9:0]        dy;
  logic signed [9:0]        dx0;
  logic signed [ACC_W-1:0]  pa_x, pb_x, pc_x, pd_x, dy_x, dx_x;
  logic signed [ACC_W-1:0]  hoff, voff;
  logic signed [ACC_W-1:0]  tx_start, ty_start;
  logic signed [ACC_W-1:0]  tx_acc, ty_acc;
  logic [ACC_W-FRAC_W-1:0]  tx_int, ty_int;

  // Offsets from the bounding-box centre, measured from its top-left column.
  assign dy  = signed'({2'b00, ry}) - signed'({2'b00, half_h});
  assign dx0 = -signed'({2'b00, half_w});

  assign pa_x = ACC_W'(signed'(pa));
  assign pb_x = ACC_W'(signed'(pb));
  assign pc_x = ACC_W'(signed'(pc));
  assign pd_x = ACC_W'(signed'(pd));
  assign dy_x = ACC_W'(dy);
  assign dx_x = ACC_W'(dx0);

  assign hoff = ACC_W'(hsize[7:1]) << FRAC_W;
  assign voff = ACC_W'(vsize[7:1]) << FRAC_W;

  assign tx_start = pa_x * dx_x + pb_x * dy_x + hoff;
  assign ty_start = pc_x * dx_x + pd_x * dy_x + voff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_acc <= '0;
      ty_acc <= '0;
    end else if (load) begin
      tx_acc <= tx_start;
      ty_acc <= ty_start;
    end else if (step) begin
      tx_acc <= tx_acc + pa_x;
      ty_acc <= ty_acc + pc_x;
    end
  end

  assign tx_int = tx_acc[ACC_W-1:FRAC_W];
  assign ty_int = ty_acc[ACC_W-1:FRAC_W];
  assign tx     = tx_acc[FRAC_W+5:FRAC_W];
  assign ty     = ty_acc[FRAC_W+5:FRAC_W];

  // Sign bit catches negative integer parts before the unsigned size compare.
  assign transparent = tx_acc[ACC_W-1] || ty_acc[ACC_W-1] ||
                       (tx_int >= (ACC_W-FRAC_W)'(hsize)) ||
                       (ty_int >= (ACC_W-FRAC_W)'(vsize));

endmodule

// File: rtl/obj_affine_seq.sv
// Sequences one affine OBJ across a scanline: row check, OAM parameter fetch,
// setup, then one column per cycle into a valid/ready pixel stream.
module obj_affine_seq
  import obj_pkg::*;
#(
  parameter int SCREEN_W = 240
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  row,
  input  logic [8:0]  objx,
  input  logic [7:0]  objy,
  input  logic [7:0]  hsize,
  input  logic [7:0]  vsize,
  input  logic        dblsize,
  input  logic [4:0]  group,
  output logic        mem_req,
  output logic [8:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_x,
  output logic [5:0]  pix_tx,
  output logic [5:0]  pix_ty,
  output logic        pix_transparent,
  output logic        pix_last,
  output logic        busy,
  output logic        done
);

  localparam logic [8:0] SCOL_END  = 9'(SCREEN_W);
  localparam logic [8:0] SCOL_LAST = 9'(SCREEN_W - 1);

  obj_state_t  state, state_nxt;
  logic [7:0]  row_r, objy_r, hsize_r, vsize_r;
  logic [8:0]  objx_r;
  logic        dblsize_r;
  logic [4:0]  group_r;
  logic [1:0]  fetch_k;
  logic        req_r;
  logic [15:0] pa, pb, pc, pd;
  logic [7:0]  col;
  logic [8:0]  bw, bh, scol;
  logic [7:0]  ry;
  logic        row_hit, on_screen, last_col, edge_col;
  logic        valid_int, advance, run_end;
  logic [5:0]  tx, ty;
  logic        transparent;

  assign bw        = {1'b0, hsize_r} << dblsize_r;
  assign bh        = {1'b0, vsize_r} << dblsize_r;
  assign ry        = row_r - objy_r;
  assign row_hit   = {1'b0, ry} < bh;
  assign scol      = objx_r + {1'b0, col};
  assign on_screen = scol < SCOL_END;
  assign last_col  = {1'b0, col} == (bw - 9'd1);
  assign edge_col  = scol == SCOL_LAST;

  // Column counter plus accumulators form the output register; they hold while stalled.
  assign valid_int = (state == ST_RUN) && on_screen;
  assign advance   = !valid_int || pix_ready;
  assign run_end   = advance && (last_col || edge_col);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_CHECK;
        ST_CHECK: state_nxt = row_hit ? ST_FETCH : ST_DONE;
        ST_FETCH: if (mem_ack && fetch_k == 2'd3) state_nxt = ST_SETUP;
        ST_SETUP: state_nxt = ST_RUN;
        ST_RUN:   if (run_end) state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_r     <= '0;
      objx_r    <= '0;
      objy_r    <= '0;
      hsize_r   <= '0;
      vsize_r   <= '0;
      dblsize_r <= 1'b0;
      group_r   <= '0;
    end else if (state == ST_IDLE && start) begin
      row_r     <= row;
      objx_r    <= objx;
      objy_r    <= objy;
      hsize_r   <= hsize;
      vsize_r   <= vsize;
      dblsize_r <= dblsize;
      group_r   <= group;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_r   <= 1'b0;
      fetch_k <= '0;
      pa      <= '0;
      pb      <= '0;
      pc      <= '0;
      pd      <= '0;
    end else if (abort) begin
      req_r   <= 1'b0;
    end else if (state == ST_CHECK && row_hit) begin
      req_r   <= 1'b1;
      fetch_k <= '0;
    end else if (state == ST_FETCH && mem_ack) begin
      case (fetch_k)
        2'd0:    pa <= mem_rdata;
        2'd1:    pb <= mem_rdata;
        2'd2:    pc <= mem_rdata;
        default: pd <= mem_rdata;
      endcase
      fetch_k <= fetch_k + 2'd1;
      if (fetch_k == 2'd3) req_r <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    col <= '0;
    else if (state == ST_SETUP)      col <= '0;
    else if (state == ST_RUN && advance) col <= col + 8'd1;
  end

  obj_affine_stepper u_stepper (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (state == ST_SETUP),
    .step        (state == ST_RUN && advance),
    .pa          (pa),
    .pb          (pb),
    .pc          (pc),
    .pd          (pd),
    .ry          (ry),
    .half_w      (bw[8:1]),
    .half_h      (bh[8:1]),
    .hsize       (hsize_r),
    .vsize       (vsize_r),
    .tx          (tx),
    .ty          (ty),
    .transparent (transparent)
  );

  assign mem_req  = req_r;
  assign mem_addr = req_r ? 9'(int'(group_r) * OAM_GROUP_STRIDE + OAM_AFF_BASE +
                               int'(fetch_k) * OAM_AFF_STRIDE) : '0;

  assign pix_valid       = valid_int;
  assign pix_x           = valid_int ? scol[7:0] : '0;
  assign pix_tx          = valid_int ? tx : '0;
  assign pix_ty          = valid_int ? ty : '0;
  assign pix_transparent = valid_int && transparent;
  assign pix_last        = valid_int && (last_col || edge_col);
  assign busy            = (state != ST_IDLE) && (state != ST_DONE);
  assign done            = (state == ST_DONE);

endmodule
